// File: rtl/lmh6401_pkg.sv
// rtl/lmh6401_pkg.sv - shared LMH6401 SPI frame layout and slave state encoding
package lmh6401_pkg;

  localparam int FRAME_BITS = 16;
  localparam int RW_BIT     = 15;
  localparam int ADDR_MSB   = 14;
  localparam int ADDR_LSB   = 8;
  localparam int DATA_MSB   = 7;
  localparam int DATA_LSB   = 0;

  // Bit counter tops out here so long frames stay distinguishable from 16
  localparam logic [4:0] BIT_CNT_SAT = 5'd17;

  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] data;
  } lmh6401_frame_t;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2,
    COMMIT    = 2'd3
  } lmh6401_slave_state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - SPI pin synchronizer with SCK edge detect
module spi_pin_sync #(
  parameter int NUM_CHANNELS = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] cs_n,
  input  logic                    sck,
  input  logic                    sdi,
  output logic [NUM_CHANNELS-1:0] cs_n_sync,
  output logic                    sdi_sync,
  output logic                    sck_rise,
  output logic                    sck_fall,
  output logic                    primed
);

  logic [NUM_CHANNELS-1:0] cs_pipe [SYNC_STAGES];
  logic [SYNC_STAGES-1:0]  sck_pipe;
  logic [SYNC_STAGES-1:0]  sdi_pipe;
  logic [SYNC_STAGES-1:0]  prime_pipe;
  logic                    sck_prev;

  // Synchronizer chains; prime_pipe marks when the chains hold real pin samples rather than reset values
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) cs_pipe[i] <= '1;
      sck_pipe   <= '0;
      sdi_pipe   <= '0;
      prime_pipe <= '0;
      sck_prev   <= 1'b0;
    end else begin
      cs_pipe[0] <= cs_n;
      for (int i = 1; i < SYNC_STAGES; i++) cs_pipe[i] <= cs_pipe[i-1];
      sck_pipe   <= {sck_pipe[SYNC_STAGES-2:0], sck};
      sdi_pipe   <= {sdi_pipe[SYNC_STAGES-2:0], sdi};
      prime_pipe <= {prime_pipe[SYNC_STAGES-2:0], 1'b1};
      sck_prev   <= sck_pipe[SYNC_STAGES-1];
    end
  end

  assign cs_n_sync = cs_pipe[SYNC_STAGES-1];
  assign sdi_sync  = sdi_pipe[SYNC_STAGES-1];
  assign sck_rise  = sck_pipe[SYNC_STAGES-1] & ~sck_prev;
  assign sck_fall  = ~sck_pipe[SYNC_STAGES-1] & sck_prev;
  assign primed    = prime_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/lmh6401_spi_slave.sv
// rtl/lmh6401_spi_slave.sv - LMH6401 SPI responder with per-channel register file and frame stream
module lmh6401_spi_slave
  import lmh6401_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int NUM_REGS     = 8,
  parameter int GAIN_ADDR    = 2,
  localparam int CHAN_W      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CHANNELS-1:0]   cs_n,
  input  logic                      sck,
  input  logic                      sdi,
  output logic                      sdo,
  output logic [15:0]               frame_data,
  output logic [CHAN_W-1:0]         frame_chan,
  output logic                      frame_valid,
  input  logic                      frame_ready,
  output logic [8*NUM_CHANNELS-1:0] gain_out,
  output logic                      err_len,
  output logic                      err_multi_cs,
  output logic                      err_overflow
);

  localparam int REG_AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  lmh6401_slave_state_t state, next_state;

  logic [NUM_CHANNELS-1:0] cs_n_sync, cs_low, chan_mask;
  logic                    sdi_sync, sck_rise, sck_fall, primed;
  logic [CHAN_W-1:0]       chan, first_low;
  logic [15:0]             shift_reg;
  logic [4:0]              bit_cnt;
  logic [7:0]              sdo_shift;
  logic                    sdo_q;
  logic [7:0]              regs [NUM_CHANNELS][NUM_REGS];
  logic                    start_frame, set_multi, set_len, do_commit;
  logic [6:0]              rd_addr;
  logic [7:0]              rd_data;
  lmh6401_frame_t          cur;

  spi_pin_sync #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .cs_n      (cs_n),
    .sck       (sck),
    .sdi       (sdi),
    .cs_n_sync (cs_n_sync),
    .sdi_sync  (sdi_sync),
    .sck_rise  (sck_rise),
    .sck_fall  (sck_fall),
    .primed    (primed)
  );

  assign cs_low    = ~cs_n_sync;
  assign chan_mask = NUM_CHANNELS'(1) << chan;
  assign cur       = shift_reg;
  assign rd_addr   = {shift_reg[5:0], sdi_sync};
  assign rd_data   = (32'(rd_addr) < NUM_REGS) ? regs[chan][rd_addr[REG_AW-1:0]] : 8'h00;
  assign do_commit = (state == COMMIT);
  assign sdo       = sdo_q & (state == SHIFT);

  // Lowest-numbered selected channel; only used when exactly one is low
  always_comb begin
    first_low = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (cs_low[i]) first_low = CHAN_W'(i);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= WAIT_IDLE;
    else       state <= next_state;
  end

  // Next-state and frame control decisions from synchronized chip selects
  always_comb begin
    next_state  = state;
    start_frame = 1'b0;
    set_multi   = 1'b0;
    set_len     = 1'b0;
    case (state)
      WAIT_IDLE: if (primed && !(|cs_low)) next_state = IDLE;
      IDLE: begin
        if (|(cs_low & (cs_low - NUM_CHANNELS'(1)))) begin
          set_multi  = 1'b1;
          next_state = WAIT_IDLE;
        end else if (|cs_low) begin
          start_frame = 1'b1;
          next_state  = SHIFT;
        end
      end
      SHIFT: begin
        if (|(cs_low & ~chan_mask)) begin
          set_multi  = 1'b1;
          next_state = WAIT_IDLE;
        end else if (!cs_low[chan]) begin
          if (bit_cnt == 5'd16) begin
            next_state = COMMIT;
          end else begin
            set_len    = 1'b1;
            next_state = IDLE;
          end
        end
      end
      COMMIT:  next_state = IDLE;
      default: next_state = WAIT_IDLE;
    endcase
  end

  // Deserializer, read-data serializer and error pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      chan         <= '0;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      sdo_shift    <= '0;
      sdo_q        <= 1'b0;
      err_len      <= 1'b0;
      err_multi_cs <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      err_len      <= set_len;
      err_multi_cs <= set_multi;
      err_overflow <= do_commit && frame_valid && !frame_ready;
      if (start_frame) begin
        chan      <= first_low;
        shift_reg <= '0;
        bit_cnt   <= '0;
        sdo_shift <= '0;
      end else if (state == SHIFT && sck_rise) begin
        shift_reg <= {shift_reg[14:0], sdi_sync};
        bit_cnt   <= (bit_cnt == BIT_CNT_SAT) ? BIT_CNT_SAT : bit_cnt + 5'd1;
        if (bit_cnt == 5'd7) sdo_shift <= shift_reg[6] ? rd_data : 8'h00;
      end
      if (state != SHIFT) begin
        sdo_q <= 1'b0;
      end else if (sck_fall) begin
        if (bit_cnt >= 5'd8 && bit_cnt <= 5'd15) begin
          sdo_q     <= sdo_shift[7];
          sdo_shift <= {sdo_shift[6:0], 1'b0};
        end else begin
          sdo_q <= 1'b0;
        end
      end
    end
  end

  // Register file; writes land on COMMIT even when the stream drops the frame
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++)
        for (int r = 0; r < NUM_REGS; r++) regs[c][r] <= 8'h00;
    end else if (do_commit && !cur.rw && 32'(cur.addr) < NUM_REGS) begin
      regs[chan][cur.addr[REG_AW-1:0]] <= cur.data;
    end
  end

  // Output stream holding register: keep an unaccepted frame, replace on same-cycle handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_valid <= 1'b0;
      frame_data  <= '0;
      frame_chan  <= '0;
    end else if (do_commit && !(frame_valid && !frame_ready)) begin
      frame_valid <= 1'b1;
      frame_data  <= shift_reg;
      frame_chan  <= chan;
    end else if (frame_valid && frame_ready) begin
      frame_valid <= 1'b0;
    end
  end

  // Export the gain register of every channel
  always_comb begin
    gain_out = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) gain_out[8*c +: 8] = regs[c][GAIN_ADDR];
  end

endmodule

// File: tb/tb_lmh6401_spi_slave.sv
// tb/tb_lmh6401_spi_slave.sv - self-checking bench for lmh6401_spi_slave
module tb_lmh6401_spi_slave;

  localparam int NCH  = 4;
  localparam int HALF = 6;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NCH-1:0]   cs_n = '1;
  logic             sck = 1'b0;
  logic             sdi = 1'b0;
  logic             sdo;
  logic [15:0]      frame_data;
  logic [1:0]       frame_chan;
  logic             frame_valid;
  logic             frame_ready = 1'b1;
  logic [8*NCH-1:0] gain_out;
  logic             err_len, err_multi_cs, err_overflow;

  lmh6401_spi_slave dut (
    .clk          (clk),
    .reset        (reset),
    .cs_n         (cs_n),
    .sck          (sck),
    .sdi          (sdi),
    .sdo          (sdo),
    .frame_data   (frame_data),
    .frame_chan   (frame_chan),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .gain_out     (gain_out),
    .err_len      (err_len),
    .err_multi_cs (err_multi_cs),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  c;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mdl_regs [NCH][8];
  int         errors = 0;
  int         checks = 0;
  int         n_len = 0, n_multi = 0, n_ovf = 0;
  int         exp_len = 0, exp_multi = 0, exp_ovf = 0;
  int         cyc = 0, rel_cyc = 0, lat = -1;
  logic       busy = 1'b1;
  logic       fv_prev = 1'b0;
  logic [7:0] rd_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_gain();
    logic [31:0] g;
    for (int c = 0; c < NCH; c++) g[8*c +: 8] = mdl_regs[c][2];
    return g;
  endfunction

  function automatic logic [7:0] model_read(input int ch, input logic [15:0] w);
    if (w[15] && w[14:8] < 7'd8) return mdl_regs[ch][w[10:8]];
    return 8'h00;
  endfunction

  // Frame-level rules: short/long frames are errors, writes below 8 update, a pending unaccepted frame blocks new ones
  function automatic void model_frame(input int ch, input logic [15:0] w, input int nbits);
    exp_t e;
    if (nbits != 16) begin
      exp_len++;
      return;
    end
    if (!w[15] && w[14:8] < 7'd8) mdl_regs[ch][w[10:8]] = w[7:0];
    if (exp_q.size() > 0 && !frame_ready) begin
      exp_ovf++;
    end else begin
      e.d = w;
      e.c = 2'(ch);
      exp_q.push_back(e);
    end
  endfunction

  always @(posedge clk) cyc++;

  // Per-cycle comparison of the stream, error pulses and gain export against the model
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_valid && !fv_prev) lat = cyc - rel_cyc;
      if (frame_valid) begin
        if (exp_q.size() == 0) begin
          chk("frame_valid_unexpected", {31'b0, frame_valid}, 32'd0);
        end else begin
          chk("frame_data", {16'b0, frame_data}, {16'b0, exp_q[0].d});
          chk("frame_chan", {30'b0, frame_chan}, {30'b0, exp_q[0].c});
          if (frame_ready) void'(exp_q.pop_front());
        end
      end
      if (err_len)      n_len++;
      if (err_multi_cs) n_multi++;
      if (err_overflow) n_ovf++;
      if (!busy) chk("gain_out", gain_out, model_gain());
    end
    fv_prev = frame_valid;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [15:0] w, input int first, input int last);
    for (int i = first; i < last; i++) begin
      sdi = (i < 16) ? w[15 - (i % 16)] : 1'b0;
      wait_clk(HALF);
      sck = 1'b1;
      if (i >= 8 && i < 16) rd_acc = {rd_acc[6:0], sdo};
      wait_clk(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic spi_xfer(input int ch, input logic [15:0] w, input int nbits, output logic [7:0] rd);
    busy = 1'b1;
    rd_acc = 8'h00;
    wait_clk(1);
    cs_n[ch] = 1'b0;
    wait_clk(HALF);
    shift_bits(w, 0, nbits);
    wait_clk(HALF);
    cs_n[ch] = 1'b1;
    rel_cyc = cyc;
    model_frame(ch, w, nbits);
    wait_clk(12);
    rd = rd_acc;
    busy = 1'b0;
  endtask

  task automatic do_frame(input int ch, input logic [15:0] w);
    logic [7:0] rd, exp_rd;
    exp_rd = model_read(ch, w);
    spi_xfer(ch, w, 16, rd);
    chk("sdo_read", {24'b0, rd}, {24'b0, exp_rd});
  endtask

  logic [15:0] vec_w  [10] = '{16'h0A5C, 16'h8A00, 16'h07E1, 16'h8700, 16'h0281,
                               16'h8200, 16'h0010, 16'h0099, 16'h8000, 16'h8200};
  int          vec_ch [10] = '{0, 0, 2, 2, 1, 1, 0, 0, 0, 2};

  initial begin
    logic [7:0] rd;
    for (int c = 0; c < NCH; c++) for (int r = 0; r < 8; r++) mdl_regs[c][r] = 8'h00;

    wait_clk(4);
    chk("reset_sdo", {31'b0, sdo}, 32'd0);
    chk("reset_frame_valid", {31'b0, frame_valid}, 32'd0);
    chk("reset_frame_data", {16'b0, frame_data}, 32'd0);
    chk("reset_frame_chan", {30'b0, frame_chan}, 32'd0);
    chk("reset_gain", gain_out, 32'd0);
    chk("reset_errs", {29'b0, err_len, err_multi_cs, err_overflow}, 32'd0);
    reset = 1'b0;
    busy = 1'b0;
    wait_clk(4);

    // Gain write on channel 1 plus pin-to-valid latency
    do_frame(1, 16'h0215);
    chk("latency", lat, 32'd4);
    chk("gain_ch1_literal", gain_out, 32'h0000_1500);

    // Write then read back on channel 3, and an out-of-range read
    do_frame(3, 16'h0233);
    chk("gain_ch3_literal", gain_out, 32'h3300_1500);
    spi_xfer(3, 16'h8200, 16, rd);
    chk("read_ch3_literal", {24'b0, rd}, 32'h33);
    spi_xfer(3, 16'h8F00, 16, rd);
    chk("read_oob_literal", {24'b0, rd}, 32'h00);

    // Directed table of writes and reads across channels and addresses
    for (int i = 0; i < 10; i++) do_frame(vec_ch[i], vec_w[i]);

    // Short and long frames
    spi_xfer(2, 16'h02AA, 12, rd);
    spi_xfer(2, 16'h02BB, 17, rd);
    chk("err_len_count", n_len, exp_len);
    chk("err_len_literal", n_len, 32'd2);

    // Second chip select dropping mid-frame
    busy = 1'b1;
    wait_clk(1);
    cs_n[0] = 1'b0;
    wait_clk(HALF);
    shift_bits(16'h0244, 0, 5);
    cs_n[2] = 1'b0;
    shift_bits(16'h0244, 5, 16);
    wait_clk(HALF);
    cs_n = '1;
    exp_multi++;
    wait_clk(12);
    busy = 1'b0;
    chk("err_multi_count", n_multi, exp_multi);
    do_frame(0, 16'h0266);

    // Stream back-pressure: second frame dropped, both register writes land
    frame_ready = 1'b0;
    do_frame(0, 16'h0211);
    do_frame(1, 16'h0222);
    wait_clk(5);
    chk("held_frame_literal", {16'b0, frame_data}, 32'h0211);
    chk("err_ovf_literal", n_ovf, 32'd1);
    frame_ready = 1'b1;
    wait_clk(5);
    chk("gain_after_ovf_literal", gain_out, 32'h3300_2211);

    // Reset in the middle of a frame
    busy = 1'b1;
    wait_clk(1);
    cs_n[1] = 1'b0;
    wait_clk(HALF);
    shift_bits(16'h0277, 0, 8);
    reset = 1'b1;
    wait_clk(2);
    reset = 1'b0;
    for (int c = 0; c < NCH; c++) for (int r = 0; r < 8; r++) mdl_regs[c][r] = 8'h00;
    shift_bits(16'h0277, 8, 16);
    wait_clk(HALF);
    cs_n[1] = 1'b1;
    wait_clk(12);
    busy = 1'b0;
    wait_clk(2);
    do_frame(2, 16'h0242);

    wait_clk(10);
    chk("err_len_final", n_len, exp_len);
    chk("err_multi_final", n_multi, exp_multi);
    chk("err_ovf_final", n_ovf, exp_ovf);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
